// File: rtl/snake_master_ctrl_pkg.sv
// Shared definitions for the snake game master sequencer.
// The state encoding is also used by the VGA colour logic and the snake navigation block.
package snake_master_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } master_state_e;

    // Older users refer to the LOSE code under this name.
    localparam logic [1:0] ST_LOWE = 2'd3;

    function automatic logic is_end_state(input master_state_e st);
        return (st == ST_WIN) || (st == ST_LOSE);
    endfunction

endpackage

// File: rtl/snake_master_ctrl_rise_detect.sv
// Rising-edge detector with a configurable history reset value.
// With RESET_VAL=1, a level held high through reset does not count as a rise.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic IN,
    output logic RISE
);

    logic prev_r;

    // History register, updated every cycle in every game state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_r <= RESET_VAL;
        end else begin
            prev_r <= IN;
        end
    end

    assign RISE = IN & ~prev_r;

endmodule

// File: rtl/snake_master_ctrl.sv
// Master sequencer: game state machine and one-cycle clear/increment strobes
// for the score counter, with a restart hold-off after WIN/LOSE.
module snake_master_ctrl
    import snake_master_ctrl_pkg::*;
#(
    parameter int unsigned SCORE_WIDTH = 4,
    parameter int unsigned WIN_SCORE   = 10,
    parameter int unsigned HOLD_CYCLES = 100000000,
    parameter int unsigned HOLD_WIDTH  = 27
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   BTN_START,
    input  logic                   REACHED_TARGET,
    input  logic                   COLLISION,
    input  logic [SCORE_WIDTH-1:0] SCORE,
    output logic                   SCORE_CLR,
    output logic                   SCORE_INC,
    output logic [1:0]             MASTER_STATE,
    output logic                   GAME_RUN
);

    localparam logic [SCORE_WIDTH-1:0] WIN_VAL  = SCORE_WIDTH'(WIN_SCORE);
    localparam logic [HOLD_WIDTH-1:0]  HOLD_MAX = HOLD_WIDTH'(HOLD_CYCLES);
    localparam logic [HOLD_WIDTH-1:0]  HOLD_ONE = HOLD_WIDTH'(1);

    master_state_e         state_r;
    logic                  clr_r;
    logic                  inc_r;
    logic                  run_r;
    logic [HOLD_WIDTH-1:0] hold_r;
    logic                  btn_rise_s;
    logic                  tgt_rise_s;

    rise_detect #(.RESET_VAL(1'b1)) u_btn_rise (
        .CLK   (CLK),
        .RESET (RESET),
        .IN    (BTN_START),
        .RISE  (btn_rise_s)
    );

    rise_detect #(.RESET_VAL(1'b1)) u_tgt_rise (
        .CLK   (CLK),
        .RESET (RESET),
        .IN    (REACHED_TARGET),
        .RISE  (tgt_rise_s)
    );

    // Game state machine with registered strobes and run flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            clr_r   <= 1'b0;
            inc_r   <= 1'b0;
            run_r   <= 1'b0;
        end else begin
            clr_r <= 1'b0;
            inc_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (btn_rise_s) begin
                        state_r <= ST_PLAY;
                        clr_r   <= 1'b1;
                        run_r   <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    // SCORE is stale while the clear is in flight, so the
                    // win compare and target rises are ignored that cycle.
                    if (COLLISION) begin
                        state_r <= ST_LOSE;
                        run_r   <= 1'b0;
                    end else if (!clr_r && (SCORE >= WIN_VAL)) begin
                        state_r <= ST_WIN;
                        run_r   <= 1'b0;
                    end else if (!clr_r && tgt_rise_s) begin
                        inc_r <= 1'b1;
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (btn_rise_s && (hold_r == HOLD_MAX)) begin
                        state_r <= ST_IDLE;
                    end
                    run_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    run_r   <= 1'b0;
                end
            endcase
        end
    end

    // Restart hold-off: zero outside WIN/LOSE, counts up and saturates inside
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold_r <= '0;
        end else if (!is_end_state(state_r)) begin
            hold_r <= '0;
        end else if (hold_r != HOLD_MAX) begin
            hold_r <= hold_r + HOLD_ONE;
        end else begin
            hold_r <= hold_r;
        end
    end

    assign SCORE_CLR    = clr_r;
    assign SCORE_INC    = inc_r;
    assign MASTER_STATE = state_r;
    assign GAME_RUN     = run_r;

endmodule

// File: tb/tb_snake_master_ctrl.sv
// Directed bench for snake_master_ctrl with a behavioural score counter and
// queues holding the cycles at which clear/increment strobes are expected.
module tb_snake_master_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_WIN  = 2'd2;
    localparam logic [1:0] S_LOSE = 2'd3;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       BTN_START;
    logic       REACHED_TARGET;
    logic       COLLISION;
    logic [3:0] SCORE;
    logic       SCORE_CLR;
    logic       SCORE_INC;
    logic [1:0] MASTER_STATE;
    logic       GAME_RUN;

    logic [3:0] cnt_r;
    logic       force_en;
    logic [3:0] force_val;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lose_cyc = 0;
    int inc_q[$];
    int clr_q[$];

    snake_master_ctrl #(
        .SCORE_WIDTH (4),
        .WIN_SCORE   (10),
        .HOLD_CYCLES (20),
        .HOLD_WIDTH  (5)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .BTN_START      (BTN_START),
        .REACHED_TARGET (REACHED_TARGET),
        .COLLISION      (COLLISION),
        .SCORE          (SCORE),
        .SCORE_CLR      (SCORE_CLR),
        .SCORE_INC      (SCORE_INC),
        .MASTER_STATE   (MASTER_STATE),
        .GAME_RUN       (GAME_RUN)
    );

    always #5 CLK = ~CLK;

    // Score counter model driven by the DUT strobes, sharing RESET
    always @(posedge CLK) begin
        if (RESET) cnt_r <= 4'd0;
        else if (SCORE_CLR) cnt_r <= 4'd0;
        else if (SCORE_INC) cnt_r <= cnt_r + 4'd1;
    end

    assign SCORE = force_en ? force_val : cnt_r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic exp_inc;
        logic exp_clr;
        @(posedge CLK);
        #1;
        cyc++;
        exp_inc = (inc_q.size() > 0) && (inc_q[0] == cyc);
        if (exp_inc) void'(inc_q.pop_front());
        exp_clr = (clr_q.size() > 0) && (clr_q[0] == cyc);
        if (exp_clr) void'(clr_q.pop_front());
        check("score_inc", 32'(SCORE_INC), 32'(exp_inc));
        check("score_clr", 32'(SCORE_CLR), 32'(exp_clr));
    endtask

    task automatic expect_state(input string tag, input logic [1:0] st, input logic run);
        check(tag, 32'(MASTER_STATE), 32'(st));
        check({tag, "_run"}, 32'(GAME_RUN), 32'(run));
    endtask

    initial begin
        RESET = 1'b1;
        BTN_START = 1'b1;
        REACHED_TARGET = 1'b0;
        COLLISION = 1'b0;
        force_en = 1'b0;
        force_val = 4'd0;
        repeat (3) tick();
        expect_state("reset", S_IDLE, 1'b0);

        // Button held high through reset must not start the game
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_state("btn_held", S_IDLE, 1'b0);
        end
        BTN_START = 1'b0;
        tick();
        expect_state("btn_low", S_IDLE, 1'b0);
        BTN_START = 1'b1;
        clr_q.push_back(cyc + 1);
        tick();
        expect_state("start", S_PLAY, 1'b1);

        // Clear cycle: stale SCORE at WIN_SCORE and a target rise, both ignored
        force_en = 1'b1;
        force_val = 4'd10;
        REACHED_TARGET = 1'b1;
        tick();
        expect_state("clr_mask", S_PLAY, 1'b1);
        force_en = 1'b0;
        REACHED_TARGET = 1'b0;
        BTN_START = 1'b0;
        tick();
        expect_state("after_clr", S_PLAY, 1'b1);
        check("score_zero", 32'(SCORE), 32'd0);

        // Ten two-cycle target pulses -> ten single increments, then WIN
        for (int i = 0; i < 10; i++) begin
            REACHED_TARGET = 1'b1;
            inc_q.push_back(cyc + 1);
            tick();
            tick();
            REACHED_TARGET = 1'b0;
            expect_state("target_play", S_PLAY, 1'b1);
            tick();
            if (i == 9) expect_state("win", S_WIN, 1'b0);
            else expect_state("target_next", S_PLAY, 1'b1);
        end
        check("score_win", 32'(SCORE), 32'd10);

        repeat (24) tick();
        expect_state("win_hold", S_WIN, 1'b0);
        check("score_held", 32'(SCORE), 32'd10);
        BTN_START = 1'b1;
        tick();
        expect_state("win_restart", S_IDLE, 1'b0);
        BTN_START = 1'b0;
        tick();

        // Second game: reach 3, then collision together with a target rise
        BTN_START = 1'b1;
        clr_q.push_back(cyc + 1);
        tick();
        expect_state("start2", S_PLAY, 1'b1);
        BTN_START = 1'b0;
        tick();
        check("score_clr2", 32'(SCORE), 32'd0);
        for (int i = 0; i < 3; i++) begin
            REACHED_TARGET = 1'b1;
            inc_q.push_back(cyc + 1);
            tick();
            tick();
            REACHED_TARGET = 1'b0;
            tick();
            tick();
        end
        expect_state("play3", S_PLAY, 1'b1);
        check("score3", 32'(SCORE), 32'd3);
        COLLISION = 1'b1;
        REACHED_TARGET = 1'b1;
        tick();
        expect_state("lose", S_LOSE, 1'b0);
        lose_cyc = cyc;
        COLLISION = 1'b0;
        REACHED_TARGET = 1'b0;
        tick();
        tick();
        check("score_lose", 32'(SCORE), 32'd3);

        // Restart presses before the hold-off expires are dropped
        while (cyc < lose_cyc + 5) tick();
        BTN_START = 1'b1;
        tick();
        expect_state("early_press5", S_LOSE, 1'b0);
        BTN_START = 1'b0;
        tick();
        while (cyc < lose_cyc + 19) tick();
        BTN_START = 1'b1;
        tick();
        expect_state("early_press19", S_LOSE, 1'b0);
        tick();
        expect_state("not_latched", S_LOSE, 1'b0);
        BTN_START = 1'b0;
        tick();
        BTN_START = 1'b1;
        tick();
        expect_state("lose_restart", S_IDLE, 1'b0);
        BTN_START = 1'b0;
        tick();

        // Third game: reset lands on the cycle an increment would be issued
        BTN_START = 1'b1;
        clr_q.push_back(cyc + 1);
        tick();
        expect_state("start3", S_PLAY, 1'b1);
        BTN_START = 1'b0;
        tick();
        REACHED_TARGET = 1'b1;
        RESET = 1'b1;
        tick();
        expect_state("reset_mid", S_IDLE, 1'b0);
        RESET = 1'b0;
        REACHED_TARGET = 1'b0;
        tick();
        expect_state("after_reset", S_IDLE, 1'b0);
        check("score_reset", 32'(SCORE), 32'd0);

        check("inc_q_empty", 32'(inc_q.size()), 32'd0);
        check("clr_q_empty", 32'(clr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
